// File: rtl/user_event_sched_pkg.sv
// Shared user-event definitions: event encoding, button indices, repeat-key set.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package user_event_sched_pkg;

  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_NEW_GAME = 3'd1,
    EV_ROTATE   = 3'd2,
    EV_LEFT     = 3'd3,
    EV_RIGHT    = 3'd4,
    EV_DOWN     = 3'd5
  } user_event_t;

  // Button indices double as arbitration priority: lower index wins.
  localparam int unsigned NUM_BTN      = 5;
  localparam int unsigned BTN_NEW_GAME = 0;
  localparam int unsigned BTN_ROTATE   = 1;
  localparam int unsigned BTN_LEFT     = 2;
  localparam int unsigned BTN_RIGHT    = 3;
  localparam int unsigned BTN_DOWN     = 4;

  // Keys that auto-repeat while held (LEFT, RIGHT, DOWN).
  localparam logic [NUM_BTN-1:0] REPEAT_KEYS = 5'b11100;

  function automatic user_event_t btn_event(input int idx);
    case (idx)
      BTN_NEW_GAME: return EV_NEW_GAME;
      BTN_ROTATE:   return EV_ROTATE;
      BTN_LEFT:     return EV_LEFT;
      BTN_RIGHT:    return EV_RIGHT;
      BTN_DOWN:     return EV_DOWN;
      default:      return EV_NONE;
    endcase
  endfunction

endpackage

// File: rtl/user_event_fifo.sv
// Synchronous show-ahead FIFO with single-cycle flush (flush+push leaves one entry).
// Latency: write visible on rdata the cycle after push; rdata is combinational from head.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
//
// Ports: clk/rst_n (async active-low), push/pop/flush controls, wdata in,
//        rdata head entry (stale when empty), empty/full status.
module user_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type data_t = logic [7:0]
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  logic  pop,
  input  logic  flush,
  input  data_t wdata,
  output data_t rdata,
  output logic  empty,
  output logic  full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  data_t           mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            do_push;
  logic            do_pop;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // A flush restarts both pointers at zero, so a concurrent push lands in slot 0.
  assign wr_en   = flush ? push : do_push;
  assign wr_addr = flush ? '0 : wr_ptr[AW-1:0];

  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? PTR_ONE : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wdata;
  end

endmodule

// File: rtl/user_event_sched.sv
// Turns debounced button levels into prioritised user events queued for the game FSM.
// Latency: press sampled at edge k -> pending at k -> FIFO entry visible after edge k+1.
// Backpressure: full FIFO holds events in per-key pending bits; repeats/presses on a pending key coalesce.
//
// Ports: main_logic_clk_i, rst_i (async active-low); btn_*_i debounced levels;
//        user_event_rd_req_i pops the head; user_event_o head (EV_NONE when empty);
//        user_event_ready_o FIFO non-empty; fifo_full_o FIFO full.
module user_event_sched
  import user_event_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned REPEAT_DELAY  = 12_500_000,
  parameter int unsigned REPEAT_PERIOD = 3_125_000
) (
  input  logic        main_logic_clk_i,
  input  logic        rst_i,
  input  logic        btn_left_i,
  input  logic        btn_right_i,
  input  logic        btn_up_i,
  input  logic        btn_down_i,
  input  logic        btn_new_game_i,
  input  logic        user_event_rd_req_i,
  output user_event_t user_event_o,
  output logic        user_event_ready_o,
  output logic        fifo_full_o
);

  localparam int unsigned CNT_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_FIRE   = CNT_W'(REPEAT_DELAY - 1);
  // Reloading to DELAY-PERIOD makes the next fire land exactly PERIOD edges later.
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [NUM_BTN-1:0] btn;
  logic [NUM_BTN-1:0] btn_q;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] rpt_fire;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] grant_vec;
  user_event_t        grant_ev;
  logic               push;
  logic               grant_ng;
  logic               fifo_empty;
  logic               fifo_full;
  user_event_t        fifo_rdata;

  assign btn[BTN_NEW_GAME] = btn_new_game_i;
  assign btn[BTN_ROTATE]   = btn_up_i;
  assign btn[BTN_LEFT]     = btn_left_i;
  assign btn[BTN_RIGHT]    = btn_right_i;
  assign btn[BTN_DOWN]     = btn_down_i;

  // btn_q is zero out of reset, so a key already held at release yields one press.
  assign press = btn & ~btn_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_key
    if (REPEAT_KEYS[i]) begin : g_rpt
      logic [CNT_W-1:0] cnt;
      logic             held;

      // Held means high on this and the previous sample; the press edge itself restarts the count.
      assign held        = btn[i] && btn_q[i];
      assign rpt_fire[i] = held && (cnt == CNT_FIRE);

      always_ff @(posedge main_logic_clk_i or negedge rst_i) begin
        if (!rst_i) begin
          cnt <= '0;
        end else if (!held) begin
          cnt <= '0;
        end else if (cnt == CNT_FIRE) begin
          cnt <= CNT_RELOAD;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end
    end else begin : g_single
      assign rpt_fire[i] = 1'b0;
    end
  end

  // A full FIFO can still accept when the reader pops in the same cycle.
  assign push = (|pending) && (!fifo_full || user_event_rd_req_i);

  // Fixed priority: scan from lowest priority upward so the lowest index wins.
  always_comb begin
    grant_vec = '0;
    grant_ev  = EV_NONE;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_vec    = '0;
        grant_vec[i] = 1'b1;
        grant_ev     = btn_event(i);
      end
    end
    if (!push) begin
      grant_vec = '0;
    end
  end

  assign grant_ng = grant_vec[BTN_NEW_GAME];

  always_ff @(posedge main_logic_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      btn_q   <= '0;
      pending <= '0;
    end else begin
      btn_q <= btn;
      if (grant_ng) begin
        // New game discards everything queued or waiting, including same-cycle arrivals.
        pending <= '0;
      end else begin
        // OR-ing into an already-set bit is what coalesces duplicate presses/repeats.
        pending <= (pending | press | rpt_fire) & ~grant_vec;
      end
    end
  end

  user_event_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .data_t (user_event_t)
  ) u_fifo (
    .clk   (main_logic_clk_i),
    .rst_n (rst_i),
    .push  (push),
    .pop   (user_event_rd_req_i),
    .flush (grant_ng),
    .wdata (grant_ev),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign user_event_o       = fifo_empty ? EV_NONE : fifo_rdata;
  assign user_event_ready_o = !fifo_empty;
  assign fifo_full_o        = fifo_full;

endmodule

// File: tb/tb_user_event_sched.sv
module tb_user_event_sched;
  import user_event_sched_pkg::*;

  localparam int DEPTH = 4;
  localparam int RD    = 4;
  localparam int RP    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic b_left = 1'b0, b_right = 1'b0, b_up = 1'b0, b_down = 1'b0, b_ng = 1'b0;
  logic rd_req = 1'b0;
  user_event_t ev;
  logic ready;
  logic full;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  user_event_sched #(
    .FIFO_DEPTH    (DEPTH),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .main_logic_clk_i    (clk),
    .rst_i               (rst_n),
    .btn_left_i          (b_left),
    .btn_right_i         (b_right),
    .btn_up_i            (b_up),
    .btn_down_i          (b_down),
    .btn_new_game_i      (b_ng),
    .user_event_rd_req_i (rd_req),
    .user_event_o        (ev),
    .user_event_ready_o  (ready),
    .fifo_full_o         (full)
  );

  // Reference model: event queue, pending set, and hold time in edges since the press.
  // Index: 0 new game, 1 rotate, 2 left, 3 right, 4 down; event code = index + 1.
  int       m_q[$];
  bit [4:0] m_pend;
  bit [4:0] m_prev;
  int       m_held[5];

  function automatic void m_reset();
    m_q.delete();
    m_pend = '0;
    m_prev = '0;
    for (int i = 0; i < 5; i++) m_held[i] = 0;
  endfunction

  function automatic void m_step(input bit [4:0] b, input bit rd);
    bit [4:0] set;
    int g;
    bit was_full;
    set = '0;
    g = -1;
    was_full = (m_q.size() == DEPTH);
    for (int i = 0; i < 5; i++) begin
      if (b[i] && !m_prev[i]) begin
        set[i] = 1'b1;
        m_held[i] = 0;
      end else if (b[i]) begin
        m_held[i]++;
        if (i >= 2 && m_held[i] >= RD && ((m_held[i] - RD) % RP) == 0) set[i] = 1'b1;
      end
    end
    for (int i = 4; i >= 0; i--) if (m_pend[i]) g = i;
    if (g >= 0 && was_full && !rd) g = -1;
    if (g == 0) begin
      m_q.delete();
      m_q.push_back(1);
      m_pend = '0;
    end else begin
      if (rd && m_q.size() > 0) void'(m_q.pop_front());
      if (g > 0) m_q.push_back(g + 1);
      m_pend = m_pend | set;
      if (g > 0) m_pend[g] = 1'b0;
    end
    m_prev = b;
  endfunction

  function automatic logic exp_ready();
    return m_q.size() > 0;
  endfunction

  function automatic logic exp_full();
    return m_q.size() == DEPTH;
  endfunction

  function automatic logic [2:0] exp_ev();
    return (m_q.size() > 0) ? 3'(m_q[0]) : 3'd0;
  endfunction

  function automatic bit [4:0] cur_btns();
    return {b_down, b_right, b_left, b_up, b_ng};
  endfunction

  task automatic set_btns(input bit [4:0] b);
    b_ng = b[0]; b_up = b[1]; b_left = b[2]; b_right = b[3]; b_down = b[4];
  endtask

  // Advance one clock: model consumes the inputs seen at the edge, outputs sampled at negedge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_step(cur_btns(), rd_req);
    @(negedge clk);
  endtask

  task automatic settle();
    set_btns('0);
    rd_req = 1'b1;
    repeat (16) tick();
    rd_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    m_reset();
    set_btns(5'b10101);
    #3;
    n_cmp++;
    if (ready !== 1'b0 || full !== 1'b0 || ev !== EV_NONE) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b full=%b ev=%0d, want 0 0 0", ready, full, ev);
    end
    tick(); tick();
    n_cmp++;
    if (ready !== 1'b0 || ev !== EV_NONE) begin
      n_err++;
      $display("FAIL reset_held_btns: got rdy=%b ev=%0d, want 0 0", ready, ev);
    end
    set_btns('0);
    rst_n = 1'b1;
    tick(); tick();
    n_cmp++;
    if (ready !== 1'b0 || full !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: got rdy=%b full=%b, want 0 0", ready, full);
    end
  endtask

  task automatic test_single_press();
    b_up = 1'b1;
    tick();
    b_up = 1'b0;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL single_press_edge_k: got rdy=%b, want 0", ready);
    end
    tick();
    n_cmp++;
    if (ready !== 1'b1 || ev !== EV_ROTATE) begin
      n_err++;
      $display("FAIL single_press_edge_k1: got rdy=%b ev=%0d, want 1 %0d", ready, ev, EV_ROTATE);
    end
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    n_cmp++;
    if (ready !== 1'b0 || ev !== EV_NONE || ready !== exp_ready()) begin
      n_err++;
      $display("FAIL single_press_pop: got rdy=%b ev=%0d, want 0 0", ready, ev);
    end
  endtask

  task automatic test_hold_repeat();
    logic [13:0] seen;
    seen = '0;
    b_left = 1'b1;
    rd_req = 1'b1;
    for (int j = 0; j < 14; j++) begin
      tick();
      seen[j] = ready && (ev == EV_LEFT);
      n_cmp++;
      if (ready !== exp_ready() || ev !== exp_ev() || full !== exp_full()) begin
        n_err++;
        $display("FAIL hold_repeat_model j=%0d: got rdy=%b ev=%0d, want %b %0d", j, ready, ev, exp_ready(), exp_ev());
      end
      if (j == 9) b_left = 1'b0;
    end
    rd_req = 1'b0;
    n_cmp++;
    if (seen !== 14'h02A2) begin
      n_err++;
      $display("FAIL hold_repeat_timing: got mask=%h, want 02a2", seen);
    end
  endtask

  task automatic test_same_cycle();
    user_event_t want[3];
    want[0] = EV_ROTATE; want[1] = EV_LEFT; want[2] = EV_DOWN;
    set_btns(5'b10110);
    tick();
    set_btns('0);
    tick(); tick(); tick();
    n_cmp++;
    if (m_q.size() != 3 || ready !== 1'b1 || full !== 1'b0 || ev !== EV_ROTATE) begin
      n_err++;
      $display("FAIL same_cycle_fill: got rdy=%b full=%b ev=%0d model_cnt=%0d, want 1 0 %0d 3", ready, full, ev, m_q.size(), EV_ROTATE);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (ev !== want[k] || ready !== 1'b1) begin
        n_err++;
        $display("FAIL same_cycle_order k=%0d: got ev=%0d, want %0d", k, ev, want[k]);
      end
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
    end
    n_cmp++;
    if (ready !== 1'b0 || ev !== EV_NONE) begin
      n_err++;
      $display("FAIL same_cycle_drained: got rdy=%b ev=%0d, want 0 0", ready, ev);
    end
  endtask

  task automatic test_fill();
    user_event_t want[4];
    want[0] = EV_ROTATE; want[1] = EV_ROTATE; want[2] = EV_ROTATE; want[3] = EV_RIGHT;
    repeat (4) begin
      b_up = 1'b1; tick();
      b_up = 1'b0; tick();
    end
    n_cmp++;
    if (full !== 1'b1 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL fill_full: got full=%b rdy=%b, want 1 1", full, ready);
    end
    b_right = 1'b1; tick();
    b_right = 1'b0; tick(); tick();
    n_cmp++;
    if (full !== 1'b1 || ev !== EV_ROTATE || m_pend[3] !== 1'b1) begin
      n_err++;
      $display("FAIL fill_blocked: got full=%b ev=%0d, want 1 %0d", full, ev, EV_ROTATE);
    end
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    n_cmp++;
    if (full !== 1'b1 || full !== exp_full()) begin
      n_err++;
      $display("FAIL fill_pop_push: got full=%b, want 1", full);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (ev !== want[k] || ready !== 1'b1) begin
        n_err++;
        $display("FAIL fill_order k=%0d: got ev=%0d, want %0d", k, ev, want[k]);
      end
      rd_req = 1'b1; tick(); rd_req = 1'b0;
    end
    n_cmp++;
    if (ready !== 1'b0 || full !== 1'b0) begin
      n_err++;
      $display("FAIL fill_drained: got rdy=%b full=%b, want 0 0", ready, full);
    end
  endtask

  task automatic test_new_game();
    repeat (3) begin
      b_right = 1'b1; tick();
      b_right = 1'b0; tick();
    end
    set_btns(5'b00101);
    tick();
    set_btns('0);
    tick();
    n_cmp++;
    if (ready !== 1'b1 || ev !== EV_NEW_GAME || full !== 1'b0) begin
      n_err++;
      $display("FAIL new_game_flush: got rdy=%b ev=%0d full=%b, want 1 %0d 0", ready, ev, full, EV_NEW_GAME);
    end
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    tick(); tick();
    n_cmp++;
    if (ready !== 1'b0 || ev !== EV_NONE) begin
      n_err++;
      $display("FAIL new_game_single_entry: got rdy=%b ev=%0d, want 0 0", ready, ev);
    end
  endtask

  task automatic test_reset_mid_repeat();
    logic [7:0] seen;
    seen = '0;
    b_down = 1'b1;
    for (int j = 0; j < 7; j++) begin
      tick();
      n_cmp++;
      if (ready !== exp_ready() || ev !== exp_ev()) begin
        n_err++;
        $display("FAIL rst_mid_prefill j=%0d: got rdy=%b ev=%0d, want %b %0d", j, ready, ev, exp_ready(), exp_ev());
      end
    end
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    n_cmp++;
    if (ready !== 1'b0 || full !== 1'b0 || ev !== EV_NONE) begin
      n_err++;
      $display("FAIL rst_mid_async: got rdy=%b full=%b ev=%0d, want 0 0 0", ready, full, ev);
    end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    rd_req = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      seen[j] = ready && (ev == EV_DOWN);
      n_cmp++;
      if (ready !== exp_ready() || ev !== exp_ev()) begin
        n_err++;
        $display("FAIL rst_mid_model j=%0d: got rdy=%b ev=%0d, want %b %0d", j, ready, ev, exp_ready(), exp_ev());
      end
    end
    rd_req = 1'b0;
    b_down = 1'b0;
    n_cmp++;
    if (seen !== 8'hA2) begin
      n_err++;
      $display("FAIL rst_mid_repeat_timing: got mask=%h, want a2", seen);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      bit [4:0] b;
      b = cur_btns();
      for (int i = 1; i < 5; i++) if ($urandom_range(7) == 0) b[i] = ~b[i];
      if (b[0]) b[0] = ($urandom_range(1) == 0);
      else      b[0] = ($urandom_range(63) == 0);
      set_btns(b);
      rd_req = ($urandom_range(2) == 0);
      tick();
      n_cmp++;
      if (ready !== exp_ready() || ev !== exp_ev() || full !== exp_full()) begin
        n_err++;
        $display("FAIL random c=%0d: got rdy=%b full=%b ev=%0d, want %b %b %0d", c, ready, full, ev, exp_ready(), exp_full(), exp_ev());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    settle();
    test_hold_repeat();
    settle();
    test_same_cycle();
    settle();
    test_fill();
    settle();
    test_new_game();
    settle();
    test_reset_mid_repeat();
    settle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
